// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin N:1 stream arbiter with bounded bursts
//
// Purpose: shares one downstream stream consumer among N valid/ready
//    requesters. A one-cycle IDLE arbitration step picks the next owner
//    round-robin from r_rr_ptr. The owner may then stream up to MAX_BURST
//    beats through a single registered output stage before it must give
//    up the grant.
//
// Ports:
//    clk       in   1     clock, all logic on posedge
//    rst       in   1     synchronous reset, active high
//    in_data   in   N*W   requester data, slot i = in_data[i*W +: W]
//    in_valid  in   N     requester i presents a beat
//    in_ready  out  N     beat i accepted when in_valid[i] & in_ready[i]
//    out_data  out  W     registered output beat
//    out_src   out  SW    requester index that produced out_data
//    out_valid out  1     out_data/out_src valid
//    out_ready in   1     downstream accepts when out_valid & out_ready
//    grant     out  N     one-hot current owner, zero while idle
module stream_rr_arbiter #(
   parameter  int N         = 4,
   parameter  int W         = 8,
   parameter  int MAX_BURST = 4,
   localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_src,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    grant
);

   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_grant;
   logic [SW-1:0]   r_gidx;
   logic [SW-1:0]   r_rr_ptr;
   logic [BW-1:0]   r_burst_cnt;
   logic [W-1:0]    r_out_data;
   logic [SW-1:0]   r_out_src;
   logic            r_out_valid;

   logic            w_slot_open;
   logic            w_accept;
   logic            w_owner_valid;
   logic            w_burst_done;
   logic            w_found;
   logic [SW-1:0]   w_pick;
   logic [SW-1:0]   w_next_ptr;
   logic [W-1:0]    w_lane [N];
   logic [W-1:0]    w_sel_data;

   // Output register is free if empty or being drained this cycle.
   assign w_slot_open   = !r_out_valid || out_ready;
   assign w_owner_valid = in_valid[r_gidx];
   assign w_accept      = (r_state == S_GRANT) && w_slot_open && w_owner_valid;
   assign w_burst_done  = (r_burst_cnt == BW'(MAX_BURST - 1));
   assign w_next_ptr    = (r_gidx == SW'(N - 1)) ? '0 : r_gidx + 1'b1;

   // in_ready never looks at in_valid, so producers can wait on it safely.
   assign in_ready  = ((r_state == S_GRANT) && w_slot_open) ? r_grant : '0;
   assign grant     = r_grant;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_lane[i] = in_data[i*W +: W];
      end
   end

   assign w_sel_data = w_lane[r_gidx];

   // First valid requester at or after r_rr_ptr, wrapping modulo N.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_pick  = '0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(r_rr_ptr) + k) % N;
         if (!w_found && in_valid[SW'(idx)]) begin
            w_found = 1'b1;
            w_pick  = SW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_gidx      <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         // Output stage: a new beat replaces a draining one in the same cycle.
         if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_src   <= r_gidx;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state     <= S_GRANT;
                  r_gidx      <= w_pick;
                  r_grant     <= {{(N-1){1'b0}}, 1'b1} << w_pick;
                  r_burst_cnt <= '0;
               end
            end
            S_GRANT: begin
               // A backpressured owner keeps its grant; it only loses it by
               // using up its burst or going idle while it could have sent.
               if ((w_accept && w_burst_done) || (w_slot_open && !w_owner_valid)) begin
                  r_state     <= S_IDLE;
                  r_grant     <= '0;
                  r_rr_ptr    <= w_next_ptr;
                  r_burst_cnt <= '0;
               end else if (w_accept) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - scoreboard bench for stream_rr_arbiter
module tb_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*W-1:0]  in_data = '0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_src;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [N-1:0]    grant;

   stream_rr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: owner index (-1 = nobody), rotation pointer, beats
   // taken in the current burst, and whether the output holds a beat.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_beats = 0;
   bit m_ov    = 1'b0;

   // Producers: pending beat per requester.
   bit             b_v [N];
   logic [W-1:0]   b_d [N];
   int             seq [N];

   logic [SW+W-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic new_beat(input int i);
      b_v[i] = 1'b1;
      b_d[i] = W'(16 * i + (seq[i] % 16));
      seq[i]++;
   endtask

   task automatic cycle(input bit r, input bit ordy, input logic [N-1:0] mask,
                        input int prob, input int pdrop);
      bit               slot;
      bit               acc;
      int               a_src;
      logic [N-1:0]     exp_gnt;
      logic [N-1:0]     exp_rdy;
      @(negedge clk);
      rst       = r;
      out_ready = ordy;
      for (int i = 0; i < N; i++) begin
         in_valid[i]       = b_v[i];
         in_data[i*W +: W] = b_d[i];
      end
      #1;
      slot    = !m_ov || ordy;
      exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      exp_rdy = slot ? exp_gnt : '0;
      acc     = 1'b0;
      a_src   = m_owner;
      if (m_owner >= 0) acc = slot && b_v[m_owner];
      check("grant", 32'(grant), 32'(exp_gnt));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));

      if (r) begin
         m_owner = -1;
         m_ptr   = 0;
         m_beats = 0;
         m_ov    = 1'b0;
         exp_q.delete();
      end else begin
         if (acc) exp_q.push_back({SW'(a_src), b_d[a_src]});
         if (acc) m_ov = 1'b1;
         else if (ordy) m_ov = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
               if (m_owner < 0 && b_v[(m_ptr + k) % N]) begin
                  m_owner = (m_ptr + k) % N;
                  m_beats = 0;
               end
            end
         end else begin
            if (acc) m_beats++;
            if ((acc && m_beats == MB) || (slot && !b_v[a_src])) begin
               m_ptr   = (a_src + 1) % N;
               m_owner = -1;
            end
         end
         if (acc) b_v[a_src] = 1'b0;
      end

      for (int i = 0; i < N; i++) begin
         if (!mask[i]) b_v[i] = 1'b0;
         else if (b_v[i]) begin
            if (int'($urandom_range(99)) < pdrop) b_v[i] = 1'b0;
         end else if (int'($urandom_range(99)) < prob) new_beat(i);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks that
   // the output register is frozen while backpressured.
   bit              hold = 1'b0;
   logic [SW+W-1:0] held = '0;
   always begin
      logic [SW+W-1:0] e;
      @(negedge clk);
      #2;
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) check("hold_stable", 32'({out_src, out_data}), 32'(held));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL beat: got unexpected %0h expected none at %0t",
                        {out_src, out_data}, $time);
            end else begin
               e = exp_q.pop_front();
               check("beat", 32'({out_src, out_data}), 32'(e));
            end
         end
         hold = out_valid && !out_ready;
         held = {out_src, out_data};
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         seq[i] = 0;
         b_v[i] = 1'b0;
         b_d[i] = '0;
      end
      // Reset with every requester asserting valid.
      for (int i = 0; i < N; i++) new_beat(i);
      repeat (2) cycle(1'b1, 1'b1, 4'b1111, 100, 0);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      // Single requester streaming alone.
      repeat (20) cycle(1'b0, 1'b1, 4'b0010, 100, 0);
      repeat (4)  cycle(1'b0, 1'b1, 4'b0000, 0, 0);
      // All requesters continuously valid: full round-robin bursts.
      repeat (60) cycle(1'b0, 1'b1, 4'b1111, 100, 0);
      // Random backpressure, including long stalls.
      for (int c = 0; c < 80; c++) begin
         cycle(1'b0, (c % 20) < 5 ? 1'b0 : 1'($urandom_range(1)), 4'b1111, 100, 0);
      end
      // Early release: requesters withdraw while others wait.
      repeat (60) cycle(1'b0, 1'b1, 4'b1100, 60, 20);
      // Reset in the middle of a burst while a beat is held.
      repeat (3) cycle(1'b0, 1'b1, 4'b1111, 100, 0);
      cycle(1'b0, 1'b0, 4'b1111, 100, 0);
      cycle(1'b1, 1'b0, 4'b1111, 100, 0);
      repeat (10) cycle(1'b0, 1'b1, 4'b1111, 100, 0);
      // Fully random traffic with occasional reset.
      for (int c = 0; c < 300; c++) begin
         cycle(1'($urandom_range(99) < 2), 1'($urandom_range(99) < 70),
               4'($urandom_range(15)), 50, 10);
      end
      // Drain.
      repeat (10) cycle(1'b0, 1'b1, 4'b0000, 0, 0);
      #5;
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
